// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder/subtractor.
package serial_adder_pkg;

  localparam int SA_WIDTH_MIN = 2;
  localparam int SA_WIDTH_MAX = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } sa_state_t;

endpackage

// File: rtl/serial_adder_if.sv
// START/BUSY/DONE handshake bundle with operands and results.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/serial_adder_full_adder.sv
// One-bit combinational full adder cell.
module serial_adder_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full adder cell, LSB first, one bit per clock.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int            CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  if (WIDTH < SA_WIDTH_MIN || WIDTH > SA_WIDTH_MAX) begin : g_width_check
    $error("serial_adder: WIDTH must be in 2..64");
  end

  sa_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fa_sum_s;
  logic             fa_co_s;

  serial_adder_full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_sum_s),
    .co (fa_co_s)
  );

  // Next-state and datapath update for the IDLE/RUN/FIN sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Subtraction is A + ~B + 1.
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          s_d     = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        s_d     = {fa_sum_s, s_q[WIDTH-1:1]};
        carry_d = fa_co_s;
        if (cnt_q == LAST) begin
          cout_d  = fa_co_s;
          ovf_d   = carry_q ^ fa_co_s;
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=16.
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_adder_if #(.WIDTH(8))  if8 ();
  serial_adder_if #(.WIDTH(16)) if16 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One 8-bit request; reports latency in edges and handshake state around it.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, output logic [7:0] s, output logic co,
                        output logic ov, output int lat, output logic busy_run,
                        output logic done_after, output logic busy_after);
    @(negedge clk);
    if8.a = a; if8.b = b; if8.cin = cin; if8.sub = sub; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    busy_run = if8.busy;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (if8.done) begin
        lat = i;
        break;
      end
    end
    s = if8.s; co = if8.cout; ov = if8.ovf;
    @(posedge clk); #1;
    done_after = if8.done;
    busy_after = if8.busy;
  endtask

  task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, output logic [15:0] s, output logic co,
                         output logic ov, output int lat);
    @(negedge clk);
    if16.a = a; if16.b = b; if16.cin = cin; if16.sub = sub; if16.start = 1'b1;
    @(posedge clk); #1;
    if16.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (if16.done) begin
        lat = i;
        break;
      end
    end
    s = if16.s; co = if16.cout; ov = if16.ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if ({if8.busy, if8.done, if8.s, if8.cout, if8.ovf} !== 11'd0) begin
      bad++;
      $display("FAIL reset8 got busy=%b done=%b s=%h cout=%b ovf=%b want all 0",
               if8.busy, if8.done, if8.s, if8.cout, if8.ovf);
    end
    total++;
    if ({if16.busy, if16.done, if16.s, if16.cout, if16.ovf} !== 19'd0) begin
      bad++;
      $display("FAIL reset16 got busy=%b done=%b s=%h want all 0", if16.busy, if16.done, if16.s);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_op8(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic sub, input logic [7:0] exp_s,
                           input logic exp_co, input logic exp_ov);
    logic [7:0] s;
    logic co, ov, busy_run, done_after, busy_after;
    int lat;
    do_op8(a, b, cin, sub, s, co, ov, lat, busy_run, done_after, busy_after);
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL %s latency got %0d want 8", name, lat);
    end
    total++;
    if ({s, co, ov} !== {exp_s, exp_co, exp_ov}) begin
      bad++;
      $display("FAIL %s result got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b",
               name, s, co, ov, exp_s, exp_co, exp_ov);
    end
    total++;
    if ({busy_run, done_after, busy_after} !== 3'b100) begin
      bad++;
      $display("FAIL %s handshake got busy_run=%b done_after=%b busy_after=%b want 1,0,0",
               name, busy_run, done_after, busy_after);
    end
  endtask

  task automatic test_zero();
    check_op8("zero", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_add();
    check_op8("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_op8("add_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    check_op8("add_cin",  8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);
  endtask

  task automatic test_sub();
    check_op8("sub_borrow", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    check_op8("sub_ovf",    8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    check_op8("sub_cin_ign", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0);
  endtask

  // START and operand churn during RUN and FIN must not disturb the first request.
  task automatic test_ignore();
    int lat;
    @(negedge clk);
    if8.a = 8'h12; if8.b = 8'h34; if8.cin = 1'b0; if8.sub = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if8.start = (i < 8) ? 1'b1 : 1'b0;
      if8.a = 8'hA5 ^ 8'(i);
      if8.b = 8'h5A;
      if8.sub = 1'b1;
      if8.cin = 1'b1;
      @(posedge clk); #1;
      if (if8.done) begin
        lat = i;
        break;
      end
    end
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL ignore latency got %0d want 8", lat);
    end
    total++;
    if ({if8.s, if8.cout, if8.ovf} !== {8'h46, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL ignore result got s=%h cout=%b ovf=%b want s=46 cout=0 ovf=0",
               if8.s, if8.cout, if8.ovf);
    end
    if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    total++;
    if (if8.busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_fin busy got %b want 0", if8.busy);
    end
    @(posedge clk); #1;
    total++;
    if ({if8.busy, if8.s} !== {1'b0, 8'h46}) begin
      bad++;
      $display("FAIL ignore_fin_start got busy=%b s=%h want busy=0 s=46", if8.busy, if8.s);
    end
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b0; if8.sub = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({if8.busy, if8.s} !== {1'b1, 8'hE0}) begin
      bad++;
      $display("FAIL abort_pre got busy=%b s=%h want busy=1 s=e0", if8.busy, if8.s);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({if8.busy, if8.done, if8.s, if8.cout, if8.ovf} !== 11'd0) begin
      bad++;
      $display("FAIL abort got busy=%b done=%b s=%h cout=%b ovf=%b want all 0",
               if8.busy, if8.done, if8.s, if8.cout, if8.ovf);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (if8.done || if8.busy) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_nodone got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_back_to_back16();
    logic [15:0] a, b, bb, s, exp_s;
    logic cin, sub, co, ov, exp_co, exp_ov;
    logic [16:0] full;
    int lat;
    for (int n = 0; n < 200; n++) begin
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      bb  = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
      exp_s  = full[15:0];
      exp_co = full[16];
      exp_ov = (a[15] == bb[15]) && (exp_s[15] != a[15]);
      do_op16(a, b, cin, sub, s, co, ov, lat);
      total++;
      if (lat !== 16) begin
        bad++;
        $display("FAIL rand16[%0d] latency got %0d want 16", n, lat);
      end
      total++;
      if ({s, co, ov} !== {exp_s, exp_co, exp_ov}) begin
        bad++;
        $display("FAIL rand16[%0d] a=%h b=%h cin=%b sub=%b got s=%h c=%b v=%b want s=%h c=%b v=%b",
                 n, a, b, cin, sub, s, co, ov, exp_s, exp_co, exp_ov);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    if8.start = 1'b0; if8.sub = 1'b0; if8.a = 8'h00; if8.b = 8'h00; if8.cin = 1'b0;
    if16.start = 1'b0; if16.sub = 1'b0; if16.a = 16'h0000; if16.b = 16'h0000; if16.cin = 1'b0;
    test_reset();
    test_zero();
    test_add();
    test_sub();
    test_ignore();
    test_abort();
    test_back_to_back16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
